// File: rtl/framebuffer_ctrl.sv
// Framebuffer with CPU write port, registered VGA read port and full-frame clear engine.
// Optional double buffering with vsync-aligned bank swap when FB_DOUBLE_BUFFER_EN is defined.
module framebuffer_ctrl #(
  parameter int ColorBits = 3,
  parameter int screenX   = 320,
  parameter int screenY   = 240,
  parameter int ADDR_W    = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [8:0]           wr_x,
  input  logic [7:0]           wr_y,
  input  logic [ColorBits-1:0] wr_color,
  input  logic                 clear_req,
  input  logic [ColorBits-1:0] clear_color,
  output logic                 busy,
  input  logic [8:0]           XRead,
  input  logic [7:0]           YRead,
  output logic [ColorBits-1:0] readValueMemory,
  input  logic                 vsync,
  input  logic                 swap_req,
  output logic                 front_bank
);

  localparam int PIXELS = screenX * screenY;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int MEM_AW = $clog2(BANKS * PIXELS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [ColorBits-1:0]  color_q, color_d;
  logic [ColorBits-1:0]  rd_q, rd_d;
  logic                  rd_bank, wr_bank;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;
  logic [ColorBits-1:0]  mem_wdata;
  logic [ColorBits-1:0]  mem [BANKS*PIXELS];

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return ADDR_W'(y) * ADDR_W'(screenX) + ADDR_W'(x);
  endfunction

  function automatic logic in_range(input logic [8:0] x, input logic [7:0] y);
    return (int'(x) < screenX) && (int'(y) < screenY);
  endfunction

  // Bank 1 sits directly above bank 0 in the shared array.
  function automatic logic [MEM_AW-1:0] mem_idx(input logic bank, input logic [ADDR_W-1:0] addr);
    return bank ? MEM_AW'(addr) + MEM_AW'(PIXELS) : MEM_AW'(addr);
  endfunction

  assign wr_ready        = (state_q == IDLE) && !reset;
  assign busy            = (state_q == CLEAR);
  assign readValueMemory = rd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready && in_range(wr_x, wr_y)) begin
          mem_we    = 1'b1;
          mem_waddr = mem_idx(wr_bank, pix_addr(wr_x, wr_y));
          mem_wdata = wr_color;
        end
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clear_color;
        end
      end
      CLEAR: begin
        // A reset edge aborts the clear without touching the pixel under the counter.
        mem_we    = !reset;
        mem_waddr = mem_idx(wr_bank, cnt_q);
        mem_wdata = color_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(PIXELS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    if (in_range(XRead, YRead)) rd_d = mem[mem_idx(rd_bank, pix_addr(XRead, YRead))];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
    cnt_q   <= cnt_d;
    color_q <= color_d;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic front_q, front_d;
  logic pend_q, pend_d;
  logic vsync_q;

  always_comb begin
    front_d = front_q;
    pend_d  = pend_q | swap_req;
    // Swap only on a registered vsync falling edge, and never mid-clear.
    if (vsync_q && !vsync && pend_q && state_q != CLEAR) begin
      front_d = ~front_q;
      pend_d  = swap_req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      vsync_q <= 1'b1;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      vsync_q <= vsync;
    end
  end

  assign rd_bank    = front_q;
  assign wr_bank    = ~front_q;
  assign front_bank = front_q;
`else
  logic unused_db;
  assign unused_db  = &{1'b0, vsync, swap_req};
  assign rd_bank    = 1'b0;
  assign wr_bank    = 1'b0;
  assign front_bank = 1'b0;
`endif

endmodule
